ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port read-first block RAM in the memory subsystem. Port 0 (instruction fetch) and port 1 (load/store) each issue read/write requests through a valid/ready handshake. The block grants at most one request per cycle, drives the RAM control pins including the optional output register, and routes each response back to its originator after the fixed RAM latency. It sits between the core's fetch/LSU interfaces and one RAM instance.

## Interface
- `DATA_WIDTH`, default 32: RAM word width.
- `ADDR_WIDTH`, default 10: RAM address width.
- `READ_LATENCY`, default 2: 1 = RAM built `LOW_LATENCY`; 2 = RAM built `HIGH_PERFORMANCE`. Must match the RAM instance. Other values are illegal.

Ports:
- `clka` in 1: clock, rising edge.
- `rsta_n` in 1: reset, asynchronous, active-low.
- `p0_req_valid` / `p1_req_valid` in 1: request present.
- `p0_req_ready` / `p1_req_ready` out 1: request granted this cycle.
- `p0_req_we` / `p1_req_we` in 1: 1 = write, 0 = read.
- `p0_req_addr` / `p1_req_addr` in ADDR_WIDTH: word address.
- `p0_req_wdata` / `p1_req_wdata` in DATA_WIDTH: write data.
- `p0_rsp_valid` / `p1_rsp_valid` out 1: response for this port, single-cycle pulse.
- `p0_rsp_rdata` / `p1_rsp_rdata` out DATA_WIDTH: response data, both driven from `ram_douta`.
- `ram_addra` out ADDR_WIDTH: RAM address.
- `ram_dina` out DATA_WIDTH: RAM write data.
- `ram_wea` out 1: RAM write enable.
- `ram_ena` out 1: RAM enable.
- `ram_regcea` out 1: RAM output-register enable.
- `ram_rsta` out 1: RAM output-register reset.
- `ram_douta` in DATA_WIDTH: RAM read data.

## Operation
- **Arbitration (combinational):**
  - Exactly one of `pN_req_ready` is high when any `req_valid` is high, and neither is high otherwise.
  - A request is accepted when `valid & ready` at the rising edge.
  - A requester holds `addr`, `we` and `wdata` stable until accepted. Deasserting `valid` before acceptance is permitted.
- **RAM drive (combinational from the granted port):**
  - `ram_ena = p0_req_valid | p1_req_valid`.
  - `ram_addra`, `ram_dina` and `ram_wea` follow the granted port.
  - With no request: `ram_wea = 0` and `ram_addra` / `ram_dina` hold the port 0 values.
- **Tracking pipeline:**
  - READ_LATENCY stages of {valid, port_id}. Stage 0 loads {accepted, granted id} at each edge.
  - Stages advance every cycle. There is no stall and no response backpressure.
- **Output register control:**
  - `ram_regcea` = stage-0 valid when READ_LATENCY = 2, constant 0 when READ_LATENCY = 1.
  - `ram_rsta` = registered `~rsta_n`.
- **Responses:**
  - `pN_rsp_valid` = last stage valid & (id == N).
  - Writes also produce a response. `rdata` carries the pre-write contents (read-first).
- **Throughput:** one accepted request per cycle, sustained, any mix of ports.
- **Ordering:** responses return in acceptance order.
  - Write to address A accepted at edge T, then a read of A at T+1: the read returns the new data.
  - A read and a write to A cannot be accepted on the same edge.
- **Reset:**
  - All tracking-stage valids and the arbitration pointer clear immediately.
  - In-flight responses are dropped; no `rsp_valid` is issued for them after reset release.
  - RAM contents are untouched.

## Timing
- Reset values:
  - `pN_rsp_valid` = 0.
  - `ram_regcea` = 0.
  - `ram_rsta` = 1.
  - `pN_req_ready` and `ram_*` are combinational and follow the arbitration rules. `ram_ena` is masked to 0 while `rsta_n` = 0.
- Request accepted at the end of cycle C:
  - `pN_rsp_valid` is high in cycle C+READ_LATENCY.
  - `ram_douta` is valid in that same cycle.
- READ_LATENCY = 2: `ram_regcea` is high in cycle C+1.
- `ram_rsta` deasserts on the first edge after `rsta_n` rises.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN`, defined: round-robin arbitration.
  - On conflict, grant the port not granted most recently. Initial preference after reset is port 0.
  - The pointer updates only on an accepted grant.
- `RAM_ARB_ROUND_ROBIN_EN`, undefined: fixed priority, port 1 always wins. Port 0 may starve; this is accepted.

## Test plan
- **Single read:** reset, then RAM[5]=0xDEADBEEF, P0 read addr 5 accepted in cycle 0 → `p0_rsp_valid` in cycle 2 (1 for READ_LATENCY=1) with `p0_rsp_rdata`=0xDEADBEEF; `p1_rsp_valid` stays 0.
- **Read-first write:** RAM[7]=0x11, P1 write 0x22 to addr 7 in cycle 0, P1 read addr 7 in cycle 1 → rsp cycle 2 = 0x11, rsp cycle 3 = 0x22.
- **Contention:** both ports read continuously for 6 cycles, addrs 0x10 (P0) and 0x20 (P1).
  - RR build: grants alternate P0,P1,P0,… and responses return in the same order.
  - Fixed build: six P1 grants, `p0_req_ready`=0 throughout.
- **Back-to-back:** P0 reads addrs 0..15 consecutively → 16 consecutive `p0_rsp_valid` cycles, data in address order, no gaps.
- **Reset mid-flight:** two reads accepted, `rsta_n` pulled low one cycle later → no `rsp_valid` during or after reset, `ram_rsta`=1 while reset is asserted; next read after release returns correct data at the nominal latency.
- **Idle:** no valids for 10 cycles → `ram_ena`=0, `ram_wea`=0, both `rsp_valid`=0, RAM contents unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter and sequencer for one single-port read-first block RAM.
// Latency: grant and RAM drive are combinational; each response returns READ_LATENCY cycles after acceptance.
// Backpressure: one grant per cycle, the losing port sees ready low; responses cannot be stalled.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module ram_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   // port 0: instruction fetch
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
   // port 1: load/store
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
   // RAM pins
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [DATA_WIDTH-1:0] ram_dina,
   output logic                  ram_wea,
   output logic                  ram_ena,
   output logic                  ram_regcea,
   output logic                  ram_rsta,
   input  logic [DATA_WIDTH-1:0] ram_douta
);

   // The RAM primitive only supports the two latency builds.
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_port_arbiter: READ_LATENCY must be 1 or 2");
   end

   logic                    any_vld;   // some request present; a grant is always issued then
   logic                    gnt_id;    // 0 = port 0 granted, 1 = port 1 granted
   logic [READ_LATENCY-1:0] stg_vld;   // tracking pipeline: response expected
   logic [READ_LATENCY-1:0] stg_id;    // tracking pipeline: originating port
   logic                    rsta_q;

   assign any_vld = p0_req_valid | p1_req_valid;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_id;   // port granted most recently

   // On conflict hand the grant to the port that did not win last time.
   always_comb begin
      gnt_id = 1'b0;
      if (p0_req_valid && p1_req_valid) begin
         gnt_id = ~last_id;
      end else if (p1_req_valid) begin
         gnt_id = 1'b1;
      end
   end

   // Pointer moves only on an accepted grant; its reset value makes port 0 the first preference.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         last_id <= 1'b1;
      end else if (any_vld) begin
         last_id <= gnt_id;
      end
   end
`else
   // Fixed priority: port 1 wins whenever it asks, port 0 may starve.
   always_comb begin
      gnt_id = p1_req_valid;
   end
`endif

   assign p0_req_ready = any_vld & ~gnt_id;
   assign p1_req_ready = any_vld &  gnt_id;

   // With no request the mux rests on port 0 and the write enable is forced low.
   assign ram_addra = gnt_id ? p1_req_addr  : p0_req_addr;
   assign ram_dina  = gnt_id ? p1_req_wdata : p0_req_wdata;
   assign ram_wea   = any_vld & (gnt_id ? p1_req_we : p0_req_we);
   assign ram_ena   = any_vld & rsta_n;

   // Tracking pipeline: stage 0 captures each accepted grant, later stages shift every cycle.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         stg_vld <= '0;
         stg_id  <= '0;
      end else begin
         stg_vld[0] <= any_vld;
         stg_id[0]  <= gnt_id;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stg_vld[i] <= stg_vld[i-1];
            stg_id[i]  <= stg_id[i-1];
         end
      end
   end

   // Output-register reset is the registered inverse of rsta_n: set at once, cleared on the first edge after release.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rsta_q <= 1'b1;
      end else begin
         rsta_q <= 1'b0;
      end
   end

   assign ram_rsta = rsta_q;

   // The output register loads one cycle after the array read, only when a read is in flight.
   if (READ_LATENCY == 2) begin : g_regce
      assign ram_regcea = stg_vld[0];
   end else begin : g_no_regce
      assign ram_regcea = 1'b0;
   end

   assign p0_rsp_valid = stg_vld[READ_LATENCY-1] & ~stg_id[READ_LATENCY-1];
   assign p1_rsp_valid = stg_vld[READ_LATENCY-1] &  stg_id[READ_LATENCY-1];
   assign p0_rsp_rdata = ram_douta;
   assign p1_rsp_rdata = ram_douta;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: drives both request ports against a behavioural read-first RAM.
// Expected responses come from a shadow memory plus an in-order queue keyed on due cycle.
// Arbitration expectations follow the build option (round-robin or port-1 priority).
module tb_ram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int RL = 2;
   localparam int NW = 1 << AW;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clka;
   logic          rsta_n;
   logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
   logic [AW-1:0] p0_req_addr;
   logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
   logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
   logic [AW-1:0] p1_req_addr;
   logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
   logic [AW-1:0] ram_addra;
   logic [DW-1:0] ram_dina, ram_douta;
   logic          ram_wea, ram_ena, ram_regcea, ram_rsta;

   int errors = 0;
   int checks = 0;

   ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
      .clka(clka), .rsta_n(rsta_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_ena(ram_ena),
      .ram_regcea(ram_regcea), .ram_rsta(ram_rsta), .ram_douta(ram_douta)
   );

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   // ---------------- behavioural RAM (read-first, optional output register) ----------------
   logic [DW-1:0] mem [NW];
   logic [DW-1:0] rd_q, out_q;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   always @(posedge clka) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (ram_ena) begin
         if (ram_wea) mem[ram_addra] <= ram_dina;
         rd_q <= mem[ram_addra];
      end
      if (ram_rsta) out_q <= '0;
      else if (ram_regcea) out_q <= rd_q;
   end
   assign ram_douta = (RL == 2) ? out_q : rd_q;

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic rsp_chk(input string nm, input bit v0, input bit v1, input logic [DW-1:0] d);
      chk({nm, "_v0"}, p0_rsp_valid, v0);
      chk({nm, "_v1"}, p1_rsp_valid, v1);
      if (v0) chk({nm, "_d0"}, p0_rsp_rdata, d);
      if (v1) chk({nm, "_d1"}, p1_rsp_rdata, d);
   endtask

   function automatic logic [DW-1:0] pat(input int a);
      if (a == 5) return 32'hDEAD_BEEF;
      if (a == 7) return 32'h0000_0011;
      return 32'hC0DE_0000 + DW'(a);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      bit            port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem [NW];
   int            cyc = 0;
   bit            rst_edge = 1'b1;   // rsta_n was low at the most recent rising edge
   bit            rr_last = 1'b1;    // port granted most recently (model)
   bit            acc_prev = 1'b0;   // a request was accepted at the most recent edge

   always @(posedge clka) begin
      cyc      <= cyc + 1;
      rst_edge <= !rsta_n;
   end

   // Predict every combinational output and the response stream from the spec rules.
   always @(negedge clka) begin
      bit            g, any, we_g, e0, e1;
      logic [AW-1:0] a_g;
      logic [DW-1:0] d_g, ed;
      exp_t          ne;
      if (bd_we) ref_mem[bd_addr] = bd_data;
      if (!rsta_n) begin
         exp_q.delete();
         rr_last  = 1'b1;
         acc_prev = 1'b0;
      end
      any = p0_req_valid || p1_req_valid;
      if (p0_req_valid && p1_req_valid) g = RR ? !rr_last : 1'b1;
      else g = p1_req_valid;
      we_g = g ? p1_req_we : p0_req_we;
      a_g  = g ? p1_req_addr : p0_req_addr;
      d_g  = g ? p1_req_wdata : p0_req_wdata;
      chk("m_rdy0", p0_req_ready, any && !g);
      chk("m_rdy1", p1_req_ready, any && g);
      chk("m_ena", ram_ena, any && rsta_n);
      chk("m_wea", ram_wea, any && we_g);
      chk("m_addra", ram_addra, a_g);
      chk("m_dina", ram_dina, d_g);
      chk("m_regcea", ram_regcea, (RL == 2) && acc_prev);
      chk("m_rsta", ram_rsta, !rsta_n || rst_edge);
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e0 = !exp_q[0].port;
         e1 = exp_q[0].port;
         ed = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      rsp_chk("m_rsp", e0, e1, ed);
      acc_prev = any && rsta_n;
      if (acc_prev) begin
         ne.port = g;
         ne.data = ref_mem[a_g];
         ne.due  = cyc + RL;
         exp_q.push_back(ne);
         if (we_g) ref_mem[a_g] = d_g;
         if (RR) rr_last = g;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic drv0(input bit v, input bit we, input int a, input logic [DW-1:0] d);
      p0_req_valid = v; p0_req_we = we; p0_req_addr = AW'(a); p0_req_wdata = d;
   endtask

   task automatic drv1(input bit v, input bit we, input int a, input logic [DW-1:0] d);
      p1_req_valid = v; p1_req_we = we; p1_req_addr = AW'(a); p1_req_wdata = d;
   endtask

   task automatic idle_all();
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
   endtask

   // Leaves the bench at cycle 0: reset released and the output-register reset already cleared.
   task automatic apply_reset();
      rsta_n = 1'b0;
      idle_all();
      repeat (3) step();
      rsta_n = 1'b1;
      step();
   endtask

   function automatic bit cont_port(input int c);
      return RR ? bit'(c % 2) : 1'b1;
   endfunction

   // ---------------- combinational vectors (applied while held in reset) ----------------
   typedef struct {
      bit            v0, v1, we0, we1;
      int            a0, a1;
      bit            r0, r1, wea;
      logic [AW-1:0] addra;
      logic [DW-1:0] dina;
   } vec_t;

   localparam logic [DW-1:0] D0 = 32'hA5A5_0000;
   localparam logic [DW-1:0] D1 = 32'h5A5A_1111;

   vec_t tbl[6];

   initial begin
      logic [DW-1:0] snap [NW];
      bit acc0, acc1;
      bit cw;
      cw = !RR;   // conflict winner while the pointer sits at its reset value
      tbl[0] = '{0, 0, 0, 0, 3, 9,   0,   0,   0, 3, D0};
      tbl[1] = '{1, 0, 1, 0, 3, 9,   1,   0,   1, 3, D0};
      tbl[2] = '{0, 1, 0, 1, 3, 9,   0,   1,   1, 9, D1};
      tbl[3] = '{1, 1, 0, 1, 3, 9, !cw,  cw,  cw, cw ? 6'd9 : 6'd3, cw ? D1 : D0};
      tbl[4] = '{1, 1, 1, 0, 12, 20, !cw, cw, !cw, cw ? 6'd20 : 6'd12, cw ? D1 : D0};
      tbl[5] = '{0, 0, 1, 1, 12, 20, 0,   0,   0, 12, D0};

      rsta_n = 1'b0;
      drv0(0, 0, 0, '0);
      drv1(0, 0, 0, '0);
      step();
      for (int i = 0; i < 6; i++) begin
         drv0(tbl[i].v0, tbl[i].we0, tbl[i].a0, D0);
         drv1(tbl[i].v1, tbl[i].we1, tbl[i].a1, D1);
         @(negedge clka);
         chk($sformatf("tbl%0d_rdy0", i), p0_req_ready, tbl[i].r0);
         chk($sformatf("tbl%0d_rdy1", i), p1_req_ready, tbl[i].r1);
         chk($sformatf("tbl%0d_wea", i), ram_wea, tbl[i].wea);
         chk($sformatf("tbl%0d_addra", i), ram_addra, tbl[i].addra);
         chk($sformatf("tbl%0d_dina", i), ram_dina, tbl[i].dina);
         chk($sformatf("tbl%0d_ena", i), ram_ena, 1'b0);
         chk($sformatf("tbl%0d_regcea", i), ram_regcea, 1'b0);
         chk($sformatf("tbl%0d_rsta", i), ram_rsta, 1'b1);
         rsp_chk($sformatf("tbl%0d", i), 0, 0, '0);
         step();
      end
      idle_all();

      // Backdoor preload while reset keeps the RAM port disabled.
      for (int a = 0; a < NW; a++) begin
         bd_we = 1'b1; bd_addr = AW'(a); bd_data = pat(a);
         step();
      end
      bd_we = 1'b0;

      // Single read of address 5.
      apply_reset();
      for (int c = 0; c <= RL + 1; c++) begin
         if (c == 0) drv0(1, 0, 5, '0); else idle_all();
         @(negedge clka);
         if (c == 0) chk("single_rdy0", p0_req_ready, 1'b1);
         rsp_chk($sformatf("single_c%0d", c), c == RL, 0, 32'hDEAD_BEEF);
         step();
      end

      // Read-first: write 0x22 to address 7, then read it back.
      apply_reset();
      for (int c = 0; c <= RL + 2; c++) begin
         if (c == 0) drv1(1, 1, 7, 32'h22);
         else if (c == 1) drv1(1, 0, 7, '0);
         else idle_all();
         @(negedge clka);
         rsp_chk($sformatf("rfirst_c%0d", c), 0, (c == RL) || (c == RL + 1),
                 (c == RL) ? 32'h11 : 32'h22);
         step();
      end

      // Contention: both ports read every cycle for six cycles.
      apply_reset();
      for (int c = 0; c < 6 + RL + 1; c++) begin
         bit ev0, ev1;
         if (c < 6) begin
            drv0(1, 0, 'h10, '0);
            drv1(1, 0, 'h20, '0);
         end else idle_all();
         @(negedge clka);
         if (c < 6) begin
            chk($sformatf("cont_c%0d_rdy0", c), p0_req_ready, !cont_port(c));
            chk($sformatf("cont_c%0d_rdy1", c), p1_req_ready, cont_port(c));
         end
         ev0 = 1'b0; ev1 = 1'b0;
         if (c >= RL && c - RL < 6) begin
            ev1 = cont_port(c - RL);
            ev0 = !ev1;
         end
         rsp_chk($sformatf("cont_c%0d", c), ev0, ev1, ev1 ? pat('h20) : pat('h10));
         step();
      end

      // Back-to-back: port 0 reads addresses 0..15 with no gaps.
      apply_reset();
      for (int c = 0; c <= 16 + RL; c++) begin
         bit ev;
         int ea;
         if (c < 16) drv0(1, 0, c, '0); else idle_all();
         @(negedge clka);
         if (c < 16) chk($sformatf("b2b_c%0d_rdy0", c), p0_req_ready, 1'b1);
         ev = (c >= RL) && (c - RL < 16);
         ea = c - RL;
         rsp_chk($sformatf("b2b_c%0d", c), ev, 0, (ea == 7) ? 32'h22 : pat(ea));
         step();
      end

      // Reset while two reads are in flight.
      apply_reset();
      for (int c = 0; c <= 7 + RL + 1; c++) begin
         idle_all();
         if (c == 0) drv0(1, 0, 3, '0);
         if (c == 1) drv1(1, 0, 4, '0);
         if (c == 2) rsta_n = 1'b0;
         if (c == 5) rsta_n = 1'b1;
         if (c == 7) drv0(1, 0, 5, '0);
         @(negedge clka);
         if (c >= 2 && c <= 5) chk($sformatf("mid_c%0d_rsta", c), ram_rsta, 1'b1);
         if (c == 6) chk("mid_c6_rsta", ram_rsta, 1'b0);
         if (c >= 2) rsp_chk($sformatf("mid_c%0d", c), c == 7 + RL, 0, 32'hDEAD_BEEF);
         step();
      end

      // Idle: nothing requested, RAM untouched.
      apply_reset();
      for (int a = 0; a < NW; a++) snap[a] = mem[a];
      for (int c = 0; c < 10; c++) begin
         @(negedge clka);
         chk($sformatf("idle_c%0d_ena", c), ram_ena, 1'b0);
         chk($sformatf("idle_c%0d_wea", c), ram_wea, 1'b0);
         rsp_chk($sformatf("idle_c%0d", c), 0, 0, '0);
         step();
      end
      for (int a = 0; a < NW; a++) chk($sformatf("idle_mem%0d", a), mem[a], snap[a]);

      // Random traffic, checked entirely by the reference model.
      acc0 = 1'b0; acc1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!p0_req_valid || acc0)
            drv0($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, NW - 1)), $urandom);
         else if ($urandom_range(0, 3) == 0) p0_req_valid = 1'b0;
         if (!p1_req_valid || acc1)
            drv1($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, NW - 1)), $urandom);
         else if ($urandom_range(0, 3) == 0) p1_req_valid = 1'b0;
         @(negedge clka);
         acc0 = p0_req_valid && p0_req_ready;
         acc1 = p1_req_valid && p1_req_ready;
         step();
      end
      idle_all();
      repeat (RL + 3) step();
      for (int a = 0; a < NW; a++) chk($sformatf("final_mem%0d", a), mem[a], ref_mem[a]);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
